// File: rtl/gpr_file_sb_if.sv
// Bus between decode/writeback and the register file: write port, issue port,
// two read ports and the post-reset ready flag.
interface gpr_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data1;
  logic              rd_busy1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy2;

  modport master (
    input  ready, rd_data1, rd_busy1, rd_data2, rd_busy2,
    output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr1, rd_addr2
  );

  modport slave (
    output ready, rd_data1, rd_busy1, rd_data2, rd_busy2,
    input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr1, rd_addr2
  );
endinterface

// File: rtl/gpr_file_sb.sv
// General-purpose register file with sequenced post-reset clear, optional
// hardwired-zero R0, optional write-to-read bypass and a per-register pending scoreboard.
module gpr_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic           clk,
  input logic           rst,
  gpr_file_sb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              ready_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_ok;
  logic              iss_ok;
  logic              active;

  assign wr_ok  = bus.wr_en  && !(ZERO_REG != 0 && bus.wr_addr  == '0);
  assign iss_ok = bus.iss_en && !(ZERO_REG != 0 && bus.iss_addr == '0);
  assign active = (state == RUN) && !rst;
  assign bus.ready = ready_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
      pending <= '0;
    end else begin
      case (state)
        CLEAR: begin
          mem[cnt] <= '0;
          if (cnt == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
          // An issue in the same cycle as the write keeps the register pending.
          for (int r = 0; r < DEPTH; r++) begin
            if (iss_ok && bus.iss_addr == ADDR_W'(r))
              pending[r] <= 1'b1;
            else if (wr_ok && bus.wr_addr == ADDR_W'(r))
              pending[r] <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Returns {busy, data}; a forwarded value is never reported busy.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] res;
    res = '0;
    if (active && !(ZERO_REG != 0 && a == '0)) begin
      if (BYPASS != 0 && bus.wr_en && bus.wr_addr == a)
        res = {1'b0, bus.wr_data};
      else
        res = {pending[a], mem[a]};
    end
    return res;
  endfunction

  always_comb begin
    {bus.rd_busy1, bus.rd_data1} = lookup(bus.rd_addr1);
    {bus.rd_busy2, bus.rd_data2} = lookup(bus.rd_addr2);
  end
endmodule

// File: tb/tb_gpr_file_sb.sv
// Self-checking bench for gpr_file_sb: three parameter variants driven in lockstep,
// a reference model feeding an expected-value queue, plus directed spot checks.
module tb_gpr_file_sb;
  logic clk;
  logic rst;

  logic        s_wr_en, s_iss_en;
  logic [2:0]  s_wr_addr, s_iss_addr, s_rd_addr1, s_rd_addr2;
  logic [15:0] s_wr_data;

  int tests_run = 0;
  int tests_failed = 0;

  // Variant 0: bypass on, 1: bypass off, 2: zero register with bypass on.
  gpr_file_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_a ();
  gpr_file_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();
  gpr_file_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_c ();

  assign bus_a.wr_en = s_wr_en;   assign bus_b.wr_en = s_wr_en;   assign bus_c.wr_en = s_wr_en;
  assign bus_a.wr_addr = s_wr_addr; assign bus_b.wr_addr = s_wr_addr; assign bus_c.wr_addr = s_wr_addr;
  assign bus_a.wr_data = s_wr_data; assign bus_b.wr_data = s_wr_data; assign bus_c.wr_data = s_wr_data;
  assign bus_a.iss_en = s_iss_en; assign bus_b.iss_en = s_iss_en; assign bus_c.iss_en = s_iss_en;
  assign bus_a.iss_addr = s_iss_addr; assign bus_b.iss_addr = s_iss_addr; assign bus_c.iss_addr = s_iss_addr;
  assign bus_a.rd_addr1 = s_rd_addr1; assign bus_b.rd_addr1 = s_rd_addr1; assign bus_c.rd_addr1 = s_rd_addr1;
  assign bus_a.rd_addr2 = s_rd_addr2; assign bus_b.rd_addr2 = s_rd_addr2; assign bus_c.rd_addr2 = s_rd_addr2;

  gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             chk;
    logic [2:0]       ready;
    logic [2:0][15:0] d1;
    logic [2:0]       b1;
    logic [2:0][15:0] d2;
    logic [2:0]       b2;
  } sb_t;

  sb_t sb_q [$];

  // Reference model state (what the registers hold before the next edge).
  logic        m_known = 1'b0;
  logic        m_run = 1'b0;
  logic        m_ready = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_mem [8];
  logic [7:0]  m_pend_n = '0;
  logic [7:0]  m_pend_z = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] exp_rd(input int v, input logic [2:0] a);
    if (rst || !m_run) return '0;
    if (v == 2 && a == 3'd0) return '0;
    if (v != 1 && s_wr_en && s_wr_addr == a) return {1'b0, s_wr_data};
    return {(v == 2) ? m_pend_z[a] : m_pend_n[a], m_mem[a]};
  endfunction

  task automatic applyStimulus(input logic rst_v, input logic we, input logic [2:0] wa,
                               input logic [15:0] wd, input logic ie, input logic [2:0] ia,
                               input logic [2:0] a1, input logic [2:0] a2);
    sb_t e;
    logic [16:0] r1, r2;
    @(posedge clk);
    #1;
    rst = rst_v; s_wr_en = we; s_wr_addr = wa; s_wr_data = wd;
    s_iss_en = ie; s_iss_addr = ia; s_rd_addr1 = a1; s_rd_addr2 = a2;
    e = '0;
    e.chk = m_known;
    for (int v = 0; v < 3; v++) begin
      r1 = exp_rd(v, a1);
      r2 = exp_rd(v, a2);
      e.ready[v] = m_ready && !rst_v;
      e.d1[v] = r1[15:0]; e.b1[v] = r1[16];
      e.d2[v] = r2[15:0]; e.b2[v] = r2[16];
    end
    sb_q.push_back(e);
    if (rst_v) begin
      m_known = 1'b1; m_run = 1'b0; m_ready = 1'b0; m_cnt = 0;
      m_pend_n = '0; m_pend_z = '0;
    end else if (m_known && !m_run) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 7) begin
        m_run = 1'b1; m_ready = 1'b1;
      end else begin
        m_cnt++;
      end
    end else if (m_known) begin
      if (we) m_mem[wa] = wd;
      for (int k = 0; k < 8; k++) begin
        if (ie && ia == 3'(k)) m_pend_n[k] = 1'b1;
        else if (we && wa == 3'(k)) m_pend_n[k] = 1'b0;
        if (k != 0) begin
          if (ie && ia == 3'(k)) m_pend_z[k] = 1'b1;
          else if (we && wa == 3'(k)) m_pend_z[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input logic [2:0] a1, input logic [2:0] a2);
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, a1, a2);
  endtask

  task automatic compareVariant(input string name, input sb_t e, input int v, input logic rdy,
                                input logic [15:0] d1, input logic b1,
                                input logic [15:0] d2, input logic b2);
    checkOutput({name, ".ready"}, 32'(rdy), 32'(e.ready[v]));
    checkOutput({name, ".rd_data1"}, 32'(d1), 32'(e.d1[v]));
    checkOutput({name, ".rd_busy1"}, 32'(b1), 32'(e.b1[v]));
    checkOutput({name, ".rd_data2"}, 32'(d2), 32'(e.d2[v]));
    checkOutput({name, ".rd_busy2"}, 32'(b2), 32'(e.b2[v]));
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        compareVariant("sb_a", e, 0, bus_a.ready, bus_a.rd_data1, bus_a.rd_busy1, bus_a.rd_data2, bus_a.rd_busy2);
        compareVariant("sb_b", e, 1, bus_b.ready, bus_b.rd_data1, bus_b.rd_busy1, bus_b.rd_data2, bus_b.rd_busy2);
        compareVariant("sb_c", e, 2, bus_c.ready, bus_c.rd_data1, bus_c.rd_busy1, bus_c.rd_data2, bus_c.rd_busy2);
      end
    end
  end

  initial begin
    rst = 1'b0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_iss_en = 1'b0; s_iss_addr = '0; s_rd_addr1 = '0; s_rd_addr2 = '0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;

    // Power-up clear: ready low for 8 sampled cycles, high on the 9th.
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    for (int i = 1; i <= 9; i++) begin
      idle(3'(i), 3'(i));
      @(negedge clk);
      checkOutput("ready_seq", 32'(bus_a.ready), (i == 9) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      idle(3'(i), 3'(7 - i));
      @(negedge clk);
      checkOutput("clear_rd", 32'(bus_a.rd_data1), 32'h0);
    end

    // Plain write then readback on both ports.
    applyStimulus(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0, 3'd0);
    idle(3'd3, 3'd3);
    @(negedge clk);
    checkOutput("beef_p1", 32'(bus_a.rd_data1), 32'hBEEF);
    checkOutput("beef_p2", 32'(bus_a.rd_data2), 32'hBEEF);
    checkOutput("beef_nobyp", 32'(bus_b.rd_data1), 32'hBEEF);

    // Same-cycle bypass versus old value.
    applyStimulus(1'b0, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd5);
    @(negedge clk);
    checkOutput("byp_data", 32'(bus_a.rd_data1), 32'h1234);
    checkOutput("byp_busy", 32'(bus_a.rd_busy1), 32'h0);
    checkOutput("nobyp_old", 32'(bus_b.rd_data1), 32'h0);

    // Scoreboard set, clear, and set-wins.
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd2, 3'd2);
    applyStimulus(1'b0, 1'b1, 3'd2, 16'h0007, 1'b0, 3'd0, 3'd2, 3'd2);
    @(negedge clk);
    checkOutput("busy_set", 32'(bus_b.rd_busy1), 32'h1);
    checkOutput("busy_fwd", 32'(bus_a.rd_busy1), 32'h0);
    idle(3'd2, 3'd2);
    @(negedge clk);
    checkOutput("busy_clr", 32'(bus_b.rd_busy1), 32'h0);
    checkOutput("wr7", 32'(bus_a.rd_data1), 32'h7);
    applyStimulus(1'b0, 1'b1, 3'd2, 16'h0009, 1'b1, 3'd2, 3'd4, 3'd4);
    idle(3'd2, 3'd2);
    @(negedge clk);
    checkOutput("set_wins", 32'(bus_a.rd_busy2), 32'h1);
    checkOutput("set_wins_d", 32'(bus_a.rd_data1), 32'h9);

    // Hardwired zero R0.
    applyStimulus(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("r0_byp", 32'(bus_c.rd_data1), 32'h0);
    idle(3'd0, 3'd0);
    @(negedge clk);
    checkOutput("r0_data", 32'(bus_c.rd_data1), 32'h0);
    checkOutput("r0_busy", 32'(bus_c.rd_busy1), 32'h0);
    checkOutput("r0_norm", 32'(bus_a.rd_data1), 32'hFFFF);

    // Reset mid-RUN with R1 pending, then again at cnt=4 of the clear.
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd1, 3'd1);
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1, 3'd1);
    for (int i = 0; i < 4; i++) idle(3'd1, 3'd1);
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1, 3'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 3'd0, 16'hAAAA, 1'b1, 3'd6, 3'd0, 3'd6);
      @(negedge clk);
      checkOutput("rst_ready", 32'(bus_a.ready), 32'h0);
    end
    idle(3'd0, 3'd6);
    @(negedge clk);
    checkOutput("rst_ready_up", 32'(bus_a.ready), 32'h1);
    checkOutput("clr_wr_ign", 32'(bus_a.rd_data1), 32'h0);
    checkOutput("clr_iss_ign", 32'(bus_a.rd_busy2), 32'h0);
    idle(3'd1, 3'd2);
    @(negedge clk);
    checkOutput("pend_clr1", 32'(bus_a.rd_busy1), 32'h0);
    checkOutput("pend_clr2", 32'(bus_a.rd_busy2), 32'h0);

    // Random traffic with occasional resets, checked through the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
                    1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    end
    idle(3'd0, 3'd0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
